// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parametrised synchronous FIFO.
// Used by the interface, the storage array and the top level.
package fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AE_THRESH = 2;

    // Pointer width for a given depth; count is one bit wider so it can hold DEPTH.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param. The producer and consumer share the
// master side; the FIFO is the slave.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CNT_W = ptr_w(DEPTH) + 1;

    // wr/rd are requests sampled on every rising edge; acceptance is decided by
    // the FIFO from full/empty in that same cycle, there is no back-pressure wait.
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, rd, din,
        input  dout, rd_valid, count, empty, full,
        input  almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  wr, rd, din,
        output dout, rd_valid, count, empty, full,
        output almost_empty, almost_full, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// A read of the address being written in the same cycle returns the old word.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for a first-word-fall-through output stage.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_overflow;
    logic              r_underflow;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_rptr_adv;
    logic              w_empty;
    logic              w_full;
    fifo_flags_t       w_flags;

`ifdef FIFO_FWFT_EN
    // r_ov marks a valid head word in the output stage; count includes it, so
    // the memory holds count - r_ov words.
    logic              r_ov;
    logic [CNT_W-1:0]  w_mem_cnt;
    logic              w_load;

    assign w_empty    = !r_ov;
    assign w_mem_cnt  = r_count - CNT_W'(r_ov);
    assign w_load     = (!r_ov || w_rd_acc) && (w_mem_cnt != '0);
    assign w_rptr_adv = w_load;
`else
    logic              r_rd_valid;

    assign w_empty    = (r_count == '0);
    assign w_rptr_adv = w_rd_acc;
`endif

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    assign w_full   = (r_count == C_DEPTH);
    assign w_rd_acc = bus.rd && !w_empty;
    assign w_wr_acc = bus.wr && (!w_full || w_rd_acc);

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (bus.din),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rptr_adv) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= bus.wr && !w_wr_acc;
            r_underflow <= bus.rd && w_empty;
        end
    end

`ifdef FIFO_FWFT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
            r_ov   <= 1'b0;
        end else if (w_load) begin
            r_dout <= w_mem_rdata;
            r_ov   <= 1'b1;
        end else if (w_rd_acc) begin
            r_ov   <= 1'b0;
        end
    end

    assign bus.rd_valid = r_ov;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_dout <= w_mem_rdata;
            end
            r_rd_valid <= w_rd_acc;
        end
    end

    assign bus.rd_valid = r_rd_valid;
`endif

    always_comb begin
        w_flags              = '0;
        w_flags.empty        = w_empty;
        w_flags.full         = w_full;
        w_flags.almost_empty = (r_count <= C_AE);
        w_flags.almost_full  = (r_count >= C_AF);
        w_flags.overflow     = r_overflow;
        w_flags.underflow    = r_underflow;
    end

    assign bus.dout         = r_dout;
    assign bus.count        = r_count;
    assign bus.empty        = w_flags.empty;
    assign bus.full         = w_flags.full;
    assign bus.almost_empty = w_flags.almost_empty;
    assign bus.almost_full  = w_flags.almost_full;
    assign bus.overflow     = w_flags.overflow;
    assign bus.underflow    = w_flags.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16); builds with or
// without FIFO_FWFT_EN and follows the same macro.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Queue of stored words in arrival order; m_vis says whether the head is
    // presented on dout in the first-word-fall-through build.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_dout;
    bit                m_vis;
    bit                m_rv;
    bit                m_ov;
    bit                m_un;

    task automatic model_reset();
        exp_q.delete();
        m_dout = '0;
        m_vis  = 1'b0;
        m_rv   = 1'b0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [DATA_W-1:0] d);
        int sz;
        bit racc;
        bit wacc;
        sz = exp_q.size();
`ifdef FIFO_FWFT_EN
        racc = r && m_vis;
        m_un = r && !m_vis;
`else
        racc = r && (sz > 0);
        m_un = r && (sz == 0);
`endif
        wacc = w && ((sz < DEPTH) || racc);
        m_ov = w && !wacc;
`ifdef FIFO_FWFT_EN
        // The head is shown when it was already stored before this edge.
        if (!(m_vis && !racc)) m_vis = (sz - int'(m_vis)) > 0;
        if (racc) void'(exp_q.pop_front());
        if (wacc) exp_q.push_back(d);
        if (m_vis) m_dout = exp_q[0];
        m_rv = m_vis;
`else
        if (racc) m_dout = exp_q.pop_front();
        m_rv = racc;
        if (wacc) exp_q.push_back(d);
`endif
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all();
        int sz;
        bit exp_empty;
        sz = exp_q.size();
`ifdef FIFO_FWFT_EN
        exp_empty = !m_vis;
`else
        exp_empty = (sz == 0);
`endif
        chk("count",        int'(bus.count),        sz);
        chk("empty",        int'(bus.empty),        int'(exp_empty));
        chk("full",         int'(bus.full),         int'(sz == DEPTH));
        chk("almost_empty", int'(bus.almost_empty), int'(sz <= AE));
        chk("almost_full",  int'(bus.almost_full),  int'(sz >= AF));
        chk("overflow",     int'(bus.overflow),     int'(m_ov));
        chk("underflow",    int'(bus.underflow),    int'(m_un));
        chk("rd_valid",     int'(bus.rd_valid),     int'(m_rv));
        chk("dout",         int'(bus.dout),         int'(m_dout));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit w, input bit r, input logic [DATA_W-1:0] d);
        bus.wr  = w;
        bus.rd  = r;
        bus.din = d;
        @(posedge clk);
        #1;
        model_step(w, r, d);
        check_all();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".count"},        int'(bus.count),        0);
        chk({tag, ".empty"},        int'(bus.empty),        1);
        chk({tag, ".full"},         int'(bus.full),         0);
        chk({tag, ".almost_empty"}, int'(bus.almost_empty), 1);
        chk({tag, ".almost_full"},  int'(bus.almost_full),  0);
        chk({tag, ".dout"},         int'(bus.dout),         0);
        chk({tag, ".rd_valid"},     int'(bus.rd_valid),     0);
        chk({tag, ".overflow"},     int'(bus.overflow),     0);
        chk({tag, ".underflow"},    int'(bus.underflow),    0);
    endtask

    // Pulses reset between edges and checks the outputs before any edge.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit                wr;
        bit                rd;
        logic [DATA_W-1:0] din;
        int                cnt;
        bit                emp;
        bit                un;
        bit                rv;
        logic [DATA_W-1:0] dout;
    } vec_t;

    vec_t vecs[9];

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = '0;
        model_reset();

`ifdef FIFO_FWFT_EN
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[3] = '{1'b1, 1'b1, 8'h33, 1, 1'b1, 1'b0, 1'b0, 8'h22};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h33};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[7] = '{1'b1, 1'b1, 8'h44, 1, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h44};
`else
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[3] = '{1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[6] = '{1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h33};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h44};
`endif

        #12;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.wr  = vecs[i].wr;
            bus.rd  = vecs[i].rd;
            bus.din = vecs[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.count", i),     int'(bus.count),     vecs[i].cnt);
            chk($sformatf("vec%0d.empty", i),     int'(bus.empty),     int'(vecs[i].emp));
            chk($sformatf("vec%0d.underflow", i), int'(bus.underflow), int'(vecs[i].un));
            chk($sformatf("vec%0d.rd_valid", i),  int'(bus.rd_valid),  int'(vecs[i].rv));
            chk($sformatf("vec%0d.dout", i),      int'(bus.dout),      int'(vecs[i].dout));
            bus.wr = 1'b0;
            bus.rd = 1'b0;
        end
        mid_reset("rst_after_table");

        // Reset mid-stream with five words stored and a non-zero dout.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'hA1 + 8'(i));
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("pre_rst.count", int'(bus.count), 5);
        mid_reset("rst_mid_stream");
        cycle(1'b0, 1'b1, 8'h00);
        chk("rst_then_rd.underflow", int'(bus.underflow), 1);

        // Fill to full, then one write too many.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            if (i + 1 >= AF) chk("fill.almost_full", int'(bus.almost_full), 1);
        end
        chk("fill.full", int'(bus.full), 1);
        chk("fill.count", int'(bus.count), DEPTH);
        cycle(1'b1, 1'b0, 8'h99);
        chk("wr17.overflow", int'(bus.overflow), 1);
        chk("wr17.count", int'(bus.count), DEPTH);
        cycle(1'b0, 1'b0, 8'h00);

        // Full with simultaneous write and read: lossless.
        cycle(1'b1, 1'b1, 8'hAA);
        chk("full_wr_rd.count", int'(bus.count), DEPTH);
        chk("full_wr_rd.overflow", int'(bus.overflow), 0);
`ifndef FIFO_FWFT_EN
        chk("full_wr_rd.dout", int'(bus.dout), 0);
`endif
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        chk("drain.last_dout", int'(bus.dout), 8'hAA);
        chk("drain.empty", int'(bus.empty), 1);
        cycle(1'b0, 1'b1, 8'h00);
        chk("drain.extra_rd_underflow", int'(bus.underflow), 1);

        // Empty with simultaneous write and read.
        cycle(1'b1, 1'b1, 8'h55);
        chk("empty_wr_rd.underflow", int'(bus.underflow), 1);
        chk("empty_wr_rd.count", int'(bus.count), 1);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        chk("empty_wr_rd.read_back", int'(bus.dout), 8'h55);

`ifdef FIFO_FWFT_EN
        // Fall-through latency of a write into a drained FIFO.
        cycle(1'b1, 1'b0, 8'h3C);
        chk("fwft.not_yet_visible", int'(bus.empty), 1);
        cycle(1'b0, 1'b0, 8'h00);
        chk("fwft.dout", int'(bus.dout), 8'h3C);
        chk("fwft.empty", int'(bus.empty), 0);
        cycle(1'b0, 1'b1, 8'h00);
        chk("fwft.consumed_empty", int'(bus.empty), 1);
`endif

        // Randomised phases: fill-biased, drain-biased, balanced; pointers wrap.
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 100; n++) begin
                bit w;
                bit r;
                case (p % 3)
                    0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
                    1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
                    default: begin w = ($urandom_range(0, 1) == 1); r = ($urandom_range(0, 1) == 1); end
                endcase
                cycle(w, r, 8'($urandom_range(0, 255)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
